mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one backing-memory port between instruction fetch (read-only) and the
// data side, one outstanding transaction at a time, with D priority and I anti-starvation.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic [DATA_W/8-1:0]   d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W/8-1:0]   mem_req_we,
    output logic [DATA_W-1:0]     mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data,
    output logic                  stall,
    output logic                  proto_err
);

    localparam int         MASK_W     = DATA_W / 8;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [3:0]          starve_cnt;
    logic                owner_d;
    logic [DATA_W-1:0]   rdata_lat;
    logic                grant_any;
    logic                grant_i;

    // Fetch wins when it has been starved long enough, or when data is not asking.
    assign grant_any = i_req | d_req;
    assign grant_i   = i_req & ((starve_cnt >= STARVE_MAX) | ~d_req);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_any) state_nx = ISSUE;
            ISSUE:   if (mem_req_ready) state_nx = (mem_req_we != '0) ? ACK : WAIT;
            WAIT:    if (mem_resp_valid) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant: latch the winning request; it stays frozen until the transaction retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_d       <= 1'b1;
            starve_cnt    <= '0;
            mem_req_addr  <= '0;
            mem_req_we    <= '0;
            mem_req_wdata <= '0;
        end else if (state == IDLE && grant_any) begin
            owner_d <= ~grant_i;
            if (grant_i) begin
                starve_cnt    <= '0;
                mem_req_addr  <= i_addr;
                mem_req_we    <= {MASK_W{1'b0}};
                mem_req_wdata <= '0;
            end else begin
                if (i_req && starve_cnt < STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
                mem_req_addr  <= d_addr;
                mem_req_we    <= d_we;
                mem_req_wdata <= d_wdata;
            end
        end
    end

    // Response capture; cleared at grant so writes return zero load data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_lat <= '0;
        end else if (state == IDLE && grant_any) begin
            rdata_lat <= '0;
        end else if (state == WAIT && mem_resp_valid) begin
            rdata_lat <= mem_resp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            proto_err <= 1'b0;
        end else if (mem_resp_valid && state != WAIT) begin
            proto_err <= 1'b1;
        end
    end

    assign mem_req_valid = (state == ISSUE);
    assign i_ack         = (state == ACK) & ~owner_d;
    assign d_ack         = (state == ACK) & owner_d;
    assign i_rdata       = i_ack ? rdata_lat : '0;
    assign d_rdata       = d_ack ? rdata_lat : '0;
    assign stall         = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, contention, backpressure,
// spurious response and reset in the middle of a read.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic [3:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [3:0]        mem_req_we;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              stall;
    logic              proto_err;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_ack(i_ack),
        .i_rdata(i_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_ack(d_ack),
        .d_rdata(d_rdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .stall(stall),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected grant order with both sides always requesting: 1 = data, 0 = fetch.
    logic exp_grant [11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};

    initial begin
        logic [31:0] last_data;
        logic        resp_next;
        int          g;

        reset          = 1'b0;
        i_req          = 1'b0;
        i_addr         = '0;
        d_req          = 1'b0;
        d_we           = '0;
        d_addr         = '0;
        d_wdata        = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        repeat (2) tick();
        @(negedge clk);
        chk("rst_valid", mem_req_valid, 0);
        chk("rst_iack", i_ack, 0);
        chk("rst_dack", d_ack, 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_we", mem_req_we, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_stall", stall, 0);
        tick();
        reset = 1'b1;

        // Single fetch with zero-wait memory
        tick(); i_req = 1; i_addr = 32'h2000; mem_req_ready = 1;
        @(negedge clk); chk("f0_stall", stall, 1); chk("f0_valid", mem_req_valid, 0);
        tick();
        @(negedge clk); chk("f1_valid", mem_req_valid, 1); chk("f1_addr", mem_req_addr, 32'h2000);
        chk("f1_we", mem_req_we, 0); chk("f1_stall", stall, 1);
        tick(); mem_resp_valid = 1; mem_resp_data = 32'hDEADBEEF;
        @(negedge clk); chk("f2_valid", mem_req_valid, 0); chk("f2_iack", i_ack, 0); chk("f2_stall", stall, 1);
        tick(); mem_resp_valid = 0;
        @(negedge clk); chk("f3_iack", i_ack, 1); chk("f3_rdata", i_rdata, 32'hDEADBEEF);
        chk("f3_stall", stall, 0); chk("f3_dack", d_ack, 0);
        tick(); i_req = 0;
        @(negedge clk); chk("f4_iack", i_ack, 0); chk("f4_valid", mem_req_valid, 0);

        // Store; requester drops d_req after the latch and still gets its ack
        tick(); d_req = 1; d_we = 4'b0011; d_addr = 32'h10; d_wdata = 32'h1234;
        @(negedge clk); chk("s0_stall", stall, 1); chk("s0_valid", mem_req_valid, 0);
        tick(); d_req = 0; d_we = 4'hF; d_addr = 32'hFFFF; d_wdata = 32'hFFFF;
        @(negedge clk); chk("s1_valid", mem_req_valid, 1); chk("s1_we", mem_req_we, 4'b0011);
        chk("s1_addr", mem_req_addr, 32'h10); chk("s1_wdata", mem_req_wdata, 32'h1234);
        tick();
        @(negedge clk); chk("s2_dack", d_ack, 1); chk("s2_drdata", d_rdata, 0); chk("s2_iack", i_ack, 0);
        tick();
        @(negedge clk); chk("s3_dack", d_ack, 0); chk("s3_valid", mem_req_valid, 0);

        // Contention: both sides request continuously, D issues writes
        tick(); i_req = 1; i_addr = 32'h100; d_req = 1; d_we = 4'hF; d_addr = 32'h200; d_wdata = 32'h77;
        g = 0; resp_next = 0; last_data = '0;
        for (int c = 0; c < 100 && g < 11; c++) begin
            if (c > 0) tick();
            mem_resp_valid = resp_next;
            mem_resp_data  = 32'hCAFE0000 + 32'(g);
            if (resp_next) last_data = mem_resp_data;
            resp_next = 0;
            @(negedge clk);
            if (i_ack) chk("ct_irdata", i_rdata, last_data);
            if (mem_req_valid) begin
                chk($sformatf("ct_grant%0d", g), {31'b0, mem_req_we != 4'h0}, {31'b0, exp_grant[g]});
                if (mem_req_we == 4'h0) resp_next = 1;
                g++;
            end
        end
        chk("ct_count", g, 11);
        tick(); i_req = 0; d_req = 0; d_we = 0; mem_resp_valid = 0;
        repeat (4) tick();

        // Backpressure: request held, late address changes ignored
        i_req = 1; i_addr = 32'h3000; mem_req_ready = 0;
        for (int k = 0; k < 5; k++) begin
            tick(); i_addr = 32'(k);
            @(negedge clk);
            chk("bp_valid", mem_req_valid, 1); chk("bp_addr", mem_req_addr, 32'h3000);
            chk("bp_iack", i_ack, 0); chk("bp_stall", stall, 1);
        end
        tick(); mem_req_ready = 1;
        @(negedge clk); chk("bp_hs_valid", mem_req_valid, 1);
        tick(); mem_resp_valid = 1; mem_resp_data = 32'h55AA;
        @(negedge clk); chk("bp_wait_valid", mem_req_valid, 0);
        tick(); mem_resp_valid = 0;
        @(negedge clk); chk("bp_iack_end", i_ack, 1); chk("bp_rdata", i_rdata, 32'h55AA);
        tick(); i_req = 0;

        // Spurious response while idle
        tick(); mem_resp_valid = 1; mem_resp_data = 32'hBAD;
        @(negedge clk); chk("sp_perr_pre", proto_err, 0);
        tick(); mem_resp_valid = 0;
        @(negedge clk); chk("sp_perr", proto_err, 1); chk("sp_iack", i_ack, 0);
        chk("sp_dack", d_ack, 0); chk("sp_valid", mem_req_valid, 0);
        repeat (3) tick();
        @(negedge clk); chk("sp_perr_sticky", proto_err, 1);

        // Reset while waiting for read data
        tick(); i_req = 1; i_addr = 32'h4000;
        tick();
        tick();
        reset = 0;
        #1;
        chk("rw_valid", mem_req_valid, 0); chk("rw_addr", mem_req_addr, 0);
        chk("rw_perr", proto_err, 0); chk("rw_iack", i_ack, 0); chk("rw_rdata", i_rdata, 0);
        i_req = 0;
        tick(); reset = 1;
        tick(); i_req = 1; i_addr = 32'h5000;
        tick();
        @(negedge clk); chk("rw_new_valid", mem_req_valid, 1); chk("rw_new_addr", mem_req_addr, 32'h5000);
        tick(); mem_resp_valid = 1; mem_resp_data = 32'h600D;
        tick(); mem_resp_valid = 0;
        @(negedge clk); chk("rw_new_iack", i_ack, 1); chk("rw_new_rdata", i_rdata, 32'h600D);
        tick(); i_req = 0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
